// File: rtl/rggen_register_access_pkg.sv
// rtl/rggen_register_access_pkg.sv - shared types for the register access controller
package rggen_register_access_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_ACCESS   = 2'd1,
    STATE_RESPONSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OKAY    = 2'b00,
    STATUS_SLVERR  = 2'b10,
    STATUS_TIMEOUT = 2'b11
  } status_e;

endpackage

// File: rtl/rggen_register_access_controller_if.sv
// rtl/rggen_register_access_controller_if.sv - host command/response channel bundle
interface rggen_register_access_controller_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);

  logic                     i_command_valid;
  logic                     o_command_ready;
  logic                     i_command_write;
  logic [ADDRESS_WIDTH-1:0] i_command_address;
  logic [BUS_WIDTH-1:0]     i_command_write_data;
  logic [BUS_WIDTH/8-1:0]   i_command_strobe;
  logic                     o_response_valid;
  logic                     i_response_ready;
  logic [1:0]               o_response_status;
  logic [BUS_WIDTH-1:0]     o_response_read_data;

  modport master (
    output i_command_valid, i_command_write, i_command_address,
           i_command_write_data, i_command_strobe, i_response_ready,
    input  o_command_ready, o_response_valid, o_response_status, o_response_read_data
  );

  modport slave (
    input  i_command_valid, i_command_write, i_command_address,
           i_command_write_data, i_command_strobe, i_response_ready,
    output o_command_ready, o_response_valid, o_response_status, o_response_read_data
  );

endinterface

// File: rtl/rggen_access_timer.sv
// rtl/rggen_access_timer.sv - wait counter flagging the cycle the wait reaches TIMEOUT
module rggen_access_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int               WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WIDTH-1:0] LAST  = (TIMEOUT > 0) ? WIDTH'(TIMEOUT - 1) : '0;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Expiry is flagged on the counting cycle that makes the count equal TIMEOUT.
  assign o_expired = (TIMEOUT != 0) && i_count && (r_count == LAST);

endmodule

// File: rtl/rggen_register_access_controller.sv
// rtl/rggen_register_access_controller.sv - decodes host commands into one-hot register accesses
module rggen_register_access_controller
  import rggen_register_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  rggen_register_access_controller_if.slave   bus_if,
  output logic [REGISTERS-1:0]                o_register_valid,
  output logic                                o_register_write,
  output logic [BUS_WIDTH-1:0]                o_register_write_data,
  output logic [BUS_WIDTH-1:0]                o_register_write_mask,
  input  logic [REGISTERS-1:0]                i_register_ready,
  input  logic [REGISTERS-1:0][BUS_WIDTH-1:0] i_register_read_data
);

  localparam int                     STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int                     OFFSET_BITS  = $clog2(STROBE_WIDTH);
  localparam int                     INDEX_WIDTH  = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
  localparam logic [ADDRESS_WIDTH:0] REG_LIMIT    = (ADDRESS_WIDTH + 1)'(REGISTERS);

  state_e                  r_state, w_next_state;
  status_e                 r_status, w_next_status;
  logic [BUS_WIDTH-1:0]    r_read_data, w_next_read_data;
  logic                    r_write;
  logic [BUS_WIDTH-1:0]    r_write_data;
  logic [STROBE_WIDTH-1:0] r_strobe;
  logic [INDEX_WIDTH-1:0]  r_index;

  logic [ADDRESS_WIDTH-1:0] w_index;
  logic                     w_in_range;
  logic                     w_accept;
  logic                     w_access;
  logic                     w_active_ready;
  logic                     w_expired;
  logic [BUS_WIDTH-1:0]     w_mask;

  assign w_index        = bus_if.i_command_address >> OFFSET_BITS;
  assign w_in_range     = {1'b0, w_index} < REG_LIMIT;
  assign w_access       = (r_state == STATE_ACCESS);
  assign w_active_ready = i_register_ready[r_index];

  assign bus_if.o_command_ready = (r_state == STATE_IDLE) && !i_rst;
  assign w_accept               = bus_if.i_command_valid && bus_if.o_command_ready;

  always_comb begin
    w_next_state     = r_state;
    w_next_status    = r_status;
    w_next_read_data = r_read_data;
    case (r_state)
      STATE_IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            w_next_state = STATE_ACCESS;
          end else begin
            w_next_state     = STATE_RESPONSE;
            w_next_status    = STATUS_SLVERR;
            w_next_read_data = '0;
          end
        end
      end
      STATE_ACCESS: begin
        // Ready wins over a timeout landing in the same cycle.
        if (w_active_ready) begin
          w_next_state     = STATE_RESPONSE;
          w_next_status    = STATUS_OKAY;
          w_next_read_data = r_write ? '0 : i_register_read_data[r_index];
        end else if (w_expired) begin
          w_next_state     = STATE_RESPONSE;
          w_next_status    = STATUS_TIMEOUT;
          w_next_read_data = '0;
        end
      end
      STATE_RESPONSE: begin
        if (bus_if.i_response_ready) begin
          w_next_state = STATE_IDLE;
        end
      end
      default: w_next_state = STATE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= STATE_IDLE;
      r_status     <= STATUS_OKAY;
      r_read_data  <= '0;
      r_write      <= 1'b0;
      r_write_data <= '0;
      r_strobe     <= '0;
      r_index      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_status    <= w_next_status;
      r_read_data <= w_next_read_data;
      if (w_accept) begin
        r_write      <= bus_if.i_command_write;
        r_write_data <= bus_if.i_command_write_data;
        r_strobe     <= bus_if.i_command_strobe;
        r_index      <= INDEX_WIDTH'(w_index);
      end
    end
  end

  rggen_access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept),
    .i_count   (w_access && !w_active_ready),
    .o_expired (w_expired)
  );

  for (genvar g = 0; g < STROBE_WIDTH; g++) begin : g_mask
    assign w_mask[8*g+:8] = {8{r_strobe[g]}};
  end

  assign o_register_valid      = w_access ? (REGISTERS'(1) << r_index) : '0;
  assign o_register_write      = w_access && r_write;
  assign o_register_write_data = (w_access && r_write) ? r_write_data : '0;
  assign o_register_write_mask = (w_access && r_write) ? w_mask : '0;

  assign bus_if.o_response_valid     = (r_state == STATE_RESPONSE);
  assign bus_if.o_response_status    = r_status;
  assign bus_if.o_response_read_data = r_read_data;

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// tb/tb_rggen_register_access_controller.sv - directed and randomized bench for the access controller
module tb_rggen_register_access_controller;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 4;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          reg_valid;
  logic                   reg_write;
  logic [BW-1:0]          reg_wdata;
  logic [BW-1:0]          reg_mask;
  logic [NR-1:0]          reg_ready;
  logic [NR-1:0][BW-1:0]  reg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rggen_register_access_controller_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();

  rggen_register_access_controller #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .REGISTERS     (NR),
    .TIMEOUT       (TO)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .bus_if                (bus_if),
    .o_register_valid      (reg_valid),
    .o_register_write      (reg_write),
    .o_register_write_data (reg_wdata),
    .o_register_write_mask (reg_mask),
    .i_register_ready      (reg_ready),
    .i_register_read_data  (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding access, its wait time and its pending response.
  bit          m_access, m_resp, m_wr;
  int          m_idx, m_wait;
  logic [1:0]  m_status;
  logic [31:0] m_rdata, m_data;
  logic [3:0]  m_strb;

  task automatic model_step();
    int idx;
    if (rst) begin
      m_access = 0; m_resp = 0; m_wr = 0; m_idx = 0; m_wait = 0;
      m_status = 2'b00; m_rdata = '0; m_data = '0; m_strb = '0;
    end else if (m_resp) begin
      if (bus_if.i_response_ready) m_resp = 0;
    end else if (m_access) begin
      if (reg_ready[m_idx]) begin
        m_access = 0; m_resp = 1; m_status = 2'b00;
        m_rdata  = m_wr ? 32'h0 : reg_rdata[m_idx];
      end else begin
        m_wait++;
        if (TO != 0 && m_wait == TO) begin
          m_access = 0; m_resp = 1; m_status = 2'b11; m_rdata = 32'h0;
        end
      end
    end else if (bus_if.i_command_valid) begin
      idx = int'(bus_if.i_command_address) / (BW / 8);
      if (idx >= NR) begin
        m_resp = 1; m_status = 2'b10; m_rdata = 32'h0;
      end else begin
        m_access = 1; m_wait = 0; m_idx = idx;
        m_wr = bus_if.i_command_write; m_data = bus_if.i_command_write_data;
        m_strb = bus_if.i_command_strobe;
      end
    end
  endtask

  task automatic model_compare();
    logic [31:0] exp_mask;
    exp_mask = '0;
    for (int b = 0; b < 4; b++) if (m_strb[b]) exp_mask[8*b+:8] = 8'hFF;
    check("cmd_ready", bus_if.o_command_ready, !m_access && !m_resp && !rst);
    check("reg_valid", reg_valid, m_access ? (4'b0001 << m_idx) : 4'b0000);
    check("reg_write", reg_write, m_access && m_wr);
    check("reg_wdata", reg_wdata, (m_access && m_wr) ? m_data : 32'h0);
    check("reg_mask", reg_mask, (m_access && m_wr) ? exp_mask : 32'h0);
    check("resp_valid", bus_if.o_response_valid, m_resp);
    if (m_resp) begin
      check("resp_status", bus_if.o_response_status, m_status);
      check("resp_rdata", bus_if.o_response_read_data, m_rdata);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      model_compare();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus_if.i_command_valid      = 1'b1;
    bus_if.i_command_write      = wr;
    bus_if.i_command_address    = addr;
    bus_if.i_command_write_data = data;
    bus_if.i_command_strobe     = strb;
    @(negedge clk);
    bus_if.i_command_valid = 1'b0;
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    bus_if.i_command_valid = 1'b0; bus_if.i_command_write = 1'b0;
    bus_if.i_command_address = '0; bus_if.i_command_write_data = '0;
    bus_if.i_command_strobe = '0; bus_if.i_response_ready = 1'b0;
    reg_ready = '0; reg_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus_if.o_command_ready, 1'b0);
    check("rst_reg_valid", reg_valid, 4'b0000);
    check("rst_resp_valid", bus_if.o_response_valid, 1'b0);
    check("rst_resp_status", bus_if.o_response_status, 2'b00);
    check("rst_resp_rdata", bus_if.o_response_read_data, 32'h0);
    check("rst_mask", reg_mask, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", bus_if.o_command_ready, 1'b1);

    // Write with immediate ready: minimum latency.
    reg_ready = 4'b0010; bus_if.i_response_ready = 1'b1;
    issue(1'b1, 8'h04, 32'hA5A5_1234, 4'b0011);
    check("t1_valid", reg_valid, 4'b0010);
    check("t1_mask", reg_mask, 32'h0000_FFFF);
    check("t1_wdata", reg_wdata, 32'hA5A5_1234);
    check("t1_resp_early", bus_if.o_response_valid, 1'b0);
    @(negedge clk);
    check("t1_resp_valid", bus_if.o_response_valid, 1'b1);
    check("t1_status", bus_if.o_response_status, 2'b00);
    check("t1_rdata", bus_if.o_response_read_data, 32'h0);
    @(negedge clk);
    check("t1_back_idle", bus_if.o_command_ready, 1'b1);

    // Read with ready on the fourth access cycle.
    reg_ready = '0; reg_rdata[3] = 32'hDEAD_BEEF;
    issue(1'b0, 8'h0C, 32'hFFFF_FFFF, 4'hF);
    check("t2_read_mask", reg_mask, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      check("t2_valid", reg_valid, 4'b1000);
      if (k == 4) reg_ready = 4'b1000;
      @(negedge clk);
    end
    check("t2_resp_valid", bus_if.o_response_valid, 1'b1);
    check("t2_rdata", bus_if.o_response_read_data, 32'hDEAD_BEEF);
    check("t2_status", bus_if.o_response_status, 2'b00);
    reg_ready = '0;
    @(negedge clk);

    // Out-of-range address.
    issue(1'b0, 8'h10, 32'h0, 4'h0);
    check("t3_valid", reg_valid, 4'b0000);
    check("t3_resp_valid", bus_if.o_response_valid, 1'b1);
    check("t3_status", bus_if.o_response_status, 2'b10);
    check("t3_rdata", bus_if.o_response_read_data, 32'h0);
    @(negedge clk);

    // Timeout with only foreign ready bits, then ready on the expiry cycle.
    for (int run = 0; run < 2; run++) begin
      reg_ready = 4'b1101; reg_rdata[1] = 32'h1357_9BDF; cnt = 0;
      issue(1'b0, 8'h05, 32'h0, 4'h0);
      for (int k = 0; k < 40 && !bus_if.o_response_valid; k++) begin
        if (reg_valid == 4'b0010) cnt++;
        if (run == 1 && cnt == TO) reg_ready = 4'b1111;
        @(negedge clk);
      end
      check("t4_valid_cycles", cnt, TO);
      check("t4_resp_valid", bus_if.o_response_valid, 1'b1);
      check("t4_status", bus_if.o_response_status, (run == 0) ? 2'b11 : 2'b00);
      check("t4_rdata", bus_if.o_response_read_data, (run == 0) ? 32'h0 : 32'h1357_9BDF);
      reg_ready = '0;
      @(negedge clk);
    end

    // Response back-pressure for five cycles with a competing command.
    bus_if.i_response_ready = 1'b0; reg_ready = 4'b0001; reg_rdata[0] = 32'hCAFE_F00D;
    issue(1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    bus_if.i_command_valid = 1'b1; bus_if.i_command_address = 8'h08;
    for (int k = 0; k < 5; k++) begin
      check("t5_resp_valid", bus_if.o_response_valid, 1'b1);
      check("t5_rdata", bus_if.o_response_read_data, 32'hCAFE_F00D);
      check("t5_status", bus_if.o_response_status, 2'b00);
      check("t5_cmd_ready", bus_if.o_command_ready, 1'b0);
      @(negedge clk);
    end
    bus_if.i_command_valid = 1'b0; bus_if.i_response_ready = 1'b1; reg_ready = '0;
    @(negedge clk);
    check("t5_released", bus_if.o_response_valid, 1'b0);

    // Reset in the middle of an access.
    issue(1'b1, 8'h08, 32'h1111_2222, 4'hF);
    check("t6_valid", reg_valid, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reg_valid", reg_valid, 4'b0000);
    check("t6_reg_write", reg_write, 1'b0);
    check("t6_wdata", reg_wdata, 32'h0);
    check("t6_mask", reg_mask, 32'h0);
    check("t6_resp_valid", bus_if.o_response_valid, 1'b0);
    check("t6_cmd_ready", bus_if.o_command_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_after_cmd_ready", bus_if.o_command_ready, 1'b1);
    check("t6_after_resp", bus_if.o_response_valid, 1'b0);

    // Randomized traffic checked by the reference model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus_if.i_command_valid      = $urandom_range(0, 1);
      bus_if.i_command_write      = $urandom_range(0, 1);
      bus_if.i_command_address    = 8'($urandom_range(0, 23));
      bus_if.i_command_write_data = $urandom;
      bus_if.i_command_strobe     = 4'($urandom_range(0, 15));
      bus_if.i_response_ready     = $urandom_range(0, 1);
      for (int b = 0; b < NR; b++) begin
        reg_ready[b] = ($urandom_range(0, 9) == 0);
        reg_rdata[b] = $urandom;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
